// File: rtl/rob_retire_ctl.sv
// rob_retire_ctl
//   In-order retirement controller for the reorder buffer.
//
//   Each cycle the controller examines the EXT_COUNT-entry head window. It
//   decides how many leading entries retire and drives the ROB consume
//   interface and the architectural register-file write lanes.
//
//   A committed store has to be alone at the head of the window. It is then
//   serialised through a request/acknowledge handshake with the store buffer.
//
//   A halt request stops retirement at the next safe point. When a store
//   handshake is in flight, that safe point is the end of the handshake.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   slot_*                head window contents; slot 0 is the oldest entry
//   head_idx              ROB index of slot 0, captured for store commits
//   consume/consume_count retire request to the ROB (count is entries - 1)
//   rf_wr_en/addr/data    one architectural RF write lane per window slot
//   st_commit_req/idx     registered store commit request to the store buffer
//   st_commit_ack         store buffer accepted the commit
//   halt_req/halted       drain request and registered halted status
//   retired_count         running count of non-killed retired instructions
module rob_retire_ctl #(
  parameter int EXT_COUNT    = 4,
  parameter int DEPTH        = 16,
  parameter int DEPTHLOG2    = $clog2(DEPTH),
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT),
  parameter int DATA_W       = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [EXT_COUNT-1:0]    slot_valid,
  input  logic [EXT_COUNT-1:0]    slot_kill,
  input  logic [EXT_COUNT-1:0]    slot_is_store,
  input  logic [4:0]              slot_dest_reg   [EXT_COUNT],
  input  logic [EXT_COUNT-1:0]    slot_dest_valid,
  input  logic [DATA_W-1:0]       slot_result     [EXT_COUNT],
  input  logic [DEPTHLOG2-1:0]    head_idx,
  output logic                    consume,
  output logic [EXTCOUNTLOG2-1:0] consume_count,
  output logic [EXT_COUNT-1:0]    rf_wr_en,
  output logic [4:0]              rf_wr_addr      [EXT_COUNT],
  output logic [DATA_W-1:0]       rf_wr_data      [EXT_COUNT],
  output logic                    st_commit_req,
  output logic [DEPTHLOG2-1:0]    st_commit_idx,
  input  logic                    st_commit_ack,
  input  logic                    halt_req,
  output logic                    halted,
  output logic [31:0]             retired_count
);

  // The window length must be able to represent EXT_COUNT itself.
  localparam int NW = EXTCOUNTLOG2 + 1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   st_commit_req_q, st_commit_req_d;
  logic [DEPTHLOG2-1:0]   st_commit_idx_q, st_commit_idx_d;
  logic                   halted_q, halted_d;
  logic [31:0]            retired_count_q, retired_count_d;

  logic [NW-1:0]          win_len;
  logic                   head_store;
  logic [NW-1:0]          ret_len;
  logic                   ack_retire;
  logic [EXT_COUNT-1:0]   lane_retired;
  logic [EXT_COUNT-1:0]   lane_live;
  logic [EXT_COUNT-1:0]   lane_wr_raw;
  logic [NW-1:0]          live_cnt;

  // Number of set bits in a lane mask.
  function automatic logic [NW-1:0] popcount(input logic [EXT_COUNT-1:0] m);
    logic [NW-1:0] c;
    c = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      c = c + NW'(m[i]);
    end
    return c;
  endfunction

  // Retire length is entries minus one; the value is don't-care at length 0.
  function automatic logic [EXTCOUNTLOG2-1:0] len_to_count(input logic [NW-1:0] len);
    logic [NW-1:0] m1;
    m1 = len - NW'(1);
    return m1[EXTCOUNTLOG2-1:0];
  endfunction

  // Window scan: retire contiguous valid slots. A live store may only retire
  // from slot 0, so the scan stops in front of a live store at any later
  // slot. A killed store retires like any other killed slot.
  always_comb begin
    logic stop;
    win_len    = '0;
    stop       = 1'b0;
    head_store = slot_valid[0] & ~slot_kill[0] & slot_is_store[0];
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!stop) begin
        if (!slot_valid[i]) begin
          stop = 1'b1;
        end else if ((i > 0) && slot_is_store[i] && !slot_kill[i]) begin
          stop = 1'b1;
        end else begin
          win_len = win_len + NW'(1);
        end
      end
    end
  end

  // Next-state logic: window retirement, store handshake and halt control.
  always_comb begin
    state_d         = state_q;
    st_commit_req_d = st_commit_req_q;
    st_commit_idx_d = st_commit_idx_q;
    ret_len         = '0;
    ack_retire      = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (head_store) begin
          // The request is registered, so it is seen one cycle after the
          // store reaches slot 0.
          state_d         = S_ST_WAIT;
          st_commit_req_d = 1'b1;
          st_commit_idx_d = head_idx;
        end else begin
          ret_len = win_len;
        end
      end
      S_ST_WAIT: begin
        // An ack counts only while the request is actually up. A pending
        // halt waits until the handshake has finished.
        if (st_commit_req_q && st_commit_ack) begin
          ack_retire      = slot_valid[0];
          st_commit_req_d = 1'b0;
          state_d         = halt_req ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        if (!halt_req) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    halted_d = (state_d == S_HALT);
  end

  // Lane masks and register-file write enables. When several retiring lanes
  // target the same register, only the youngest of them writes it.
  always_comb begin
    lane_retired = '0;
    lane_live    = '0;
    lane_wr_raw  = '0;
    rf_wr_en     = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      lane_retired[i] = (NW'(i) < ret_len);
      lane_live[i]    = lane_retired[i] & ~slot_kill[i];
      lane_wr_raw[i]  = lane_live[i] & slot_dest_valid[i] & (slot_dest_reg[i] != 5'd0);
    end
    for (int i = 0; i < EXT_COUNT; i++) begin
      logic shadowed;
      shadowed = 1'b0;
      for (int j = i + 1; j < EXT_COUNT; j++) begin
        if (lane_wr_raw[j] && (slot_dest_reg[j] == slot_dest_reg[i])) begin
          shadowed = 1'b1;
        end
      end
      rf_wr_en[i] = reset_n & lane_wr_raw[i] & ~shadowed;
    end
    for (int i = 0; i < EXT_COUNT; i++) begin
      rf_wr_addr[i] = slot_dest_reg[i];
      rf_wr_data[i] = slot_result[i];
    end
  end

  // A committed store retires alone, with a count field of 0.
  always_comb begin
    consume         = reset_n & ((ret_len != '0) | ack_retire);
    consume_count   = ack_retire ? '0 : len_to_count(ret_len);
    live_cnt        = popcount(lane_live) + NW'(ack_retire);
    retired_count_d = retired_count_q + 32'(live_cnt);
  end

  // ---- state registers ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= S_RUN;
      st_commit_req_q <= 1'b0;
      st_commit_idx_q <= '0;
      halted_q        <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      st_commit_req_q <= st_commit_req_d;
      st_commit_idx_q <= st_commit_idx_d;
      halted_q        <= halted_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign st_commit_req = st_commit_req_q;
  assign st_commit_idx = st_commit_idx_q;
  assign halted        = halted_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_rob_retire_ctl.sv
// Scoreboard bench for rob_retire_ctl.
// The stimulus process pushes hand-computed expected outputs once per cycle.
// The monitor pops them on the falling edge and compares them to the DUT.
module tb_rob_retire_ctl;

  logic        clock;
  logic        reset_n;
  logic [3:0]  slot_valid;
  logic [3:0]  slot_kill;
  logic [3:0]  slot_is_store;
  logic [4:0]  slot_dest_reg   [4];
  logic [3:0]  slot_dest_valid;
  logic [31:0] slot_result     [4];
  logic [3:0]  head_idx;
  logic        consume;
  logic [1:0]  consume_count;
  logic [3:0]  rf_wr_en;
  logic [4:0]  rf_wr_addr      [4];
  logic [31:0] rf_wr_data      [4];
  logic        st_commit_req;
  logic [3:0]  st_commit_idx;
  logic        st_commit_ack;
  logic        halt_req;
  logic        halted;
  logic [31:0] retired_count;

  rob_retire_ctl #(
    .EXT_COUNT(4),
    .DEPTH(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .slot_valid(slot_valid),
    .slot_kill(slot_kill),
    .slot_is_store(slot_is_store),
    .slot_dest_reg(slot_dest_reg),
    .slot_dest_valid(slot_dest_valid),
    .slot_result(slot_result),
    .head_idx(head_idx),
    .consume(consume),
    .consume_count(consume_count),
    .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .st_commit_req(st_commit_req),
    .st_commit_idx(st_commit_idx),
    .st_commit_ack(st_commit_ack),
    .halt_req(halt_req),
    .halted(halted),
    .retired_count(retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic             cons;
    logic [1:0]       cnt;
    logic [3:0]       wen;
    logic [3:0][4:0]  addr;
    logic [3:0][31:0] data;
    logic             req;
    logic [3:0]       idx;
    logic             hlt;
    logic [31:0]      rc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("consume", 32'(consume), 32'(mon_e.cons));
      if (mon_e.cons) chk("consume_count", 32'(consume_count), 32'(mon_e.cnt));
      chk("rf_wr_en", 32'(rf_wr_en), 32'(mon_e.wen));
      for (int i = 0; i < 4; i++) begin
        if (mon_e.wen[i]) begin
          chk($sformatf("rf_wr_addr[%0d]", i), 32'(rf_wr_addr[i]), 32'(mon_e.addr[i]));
          chk($sformatf("rf_wr_data[%0d]", i), rf_wr_data[i], mon_e.data[i]);
        end
      end
      chk("st_commit_req", 32'(st_commit_req), 32'(mon_e.req));
      chk("st_commit_idx", 32'(st_commit_idx), 32'(mon_e.idx));
      chk("halted", 32'(halted), 32'(mon_e.hlt));
      chk("retired_count", retired_count, mon_e.rc);
    end
  end

  task automatic clr();
    slot_valid      = '0;
    slot_kill       = '0;
    slot_is_store   = '0;
    slot_dest_valid = '0;
    for (int i = 0; i < 4; i++) begin
      slot_dest_reg[i] = '0;
      slot_result[i]   = '0;
    end
  endtask

  // slot(index, killed, store, dest_valid, dest_reg)
  task automatic slot(input int i, input logic k, input logic st, input logic dv,
                      input logic [4:0] r);
    slot_valid[i]      = 1'b1;
    slot_kill[i]       = k;
    slot_is_store[i]   = st;
    slot_dest_valid[i] = dv;
    slot_dest_reg[i]   = r;
    slot_result[i]     = 32'hD000_0000 | (32'(r) << 8) | 32'(i);
  endtask

  // Queue the expected outputs for the current cycle, then advance one cycle.
  task automatic expect_cyc(input logic cons, input logic [1:0] cnt, input logic [3:0] wen,
                            input logic req, input logic [3:0] idx, input logic hlt,
                            input logic [31:0] rc);
    exp_t e;
    e.cons = cons;
    e.cnt  = cnt;
    e.wen  = wen;
    for (int i = 0; i < 4; i++) begin
      e.addr[i] = slot_dest_reg[i];
      e.data[i] = slot_result[i];
    end
    e.req = req;
    e.idx = idx;
    e.hlt = hlt;
    e.rc  = rc;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    halt_req      = 1'b0;
    st_commit_ack = 1'b0;
    head_idx      = '0;
    clr();
    for (int i = 0; i < 4; i++) slot(i, 1'b0, 1'b0, 1'b1, 5'(i + 1));
    @(posedge clock);
    #1;
    // Reset held with a full window: consume and writes forced low.
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 32'd0);

    // Full window r1..r4.
    reset_n = 1'b1;
    clr();
    for (int i = 0; i < 4; i++) slot(i, 1'b0, 1'b0, 1'b1, 5'(i + 1));
    expect_cyc(1'b1, 2'd3, 4'b1111, 1'b0, 4'd0, 1'b0, 32'd0);

    // Hole at slot 2 stops the window.
    clr();
    slot(0, 1'b0, 1'b0, 1'b1, 5'd5);
    slot(1, 1'b0, 1'b0, 1'b1, 5'd6);
    slot(3, 1'b0, 1'b0, 1'b1, 5'd8);
    expect_cyc(1'b1, 2'd1, 4'b0011, 1'b0, 4'd0, 1'b0, 32'd4);

    // Load, then a store at slot 1: only the load retires.
    clr();
    head_idx = 4'd14;
    slot(0, 1'b0, 1'b0, 1'b1, 5'd5);
    slot(1, 1'b0, 1'b1, 1'b0, 5'd0);
    slot(2, 1'b0, 1'b0, 1'b1, 5'd9);
    expect_cyc(1'b1, 2'd0, 4'b0001, 1'b0, 4'd0, 1'b0, 32'd6);

    // Store at slot 0: no retirement; the request rises at the next edge.
    clr();
    head_idx = 4'd15;
    slot(0, 1'b0, 1'b1, 1'b0, 5'd0);
    slot(1, 1'b0, 1'b0, 1'b1, 5'd9);
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 32'd7);
    repeat (3) expect_cyc(1'b0, 2'd0, 4'b0000, 1'b1, 4'd15, 1'b0, 32'd7);
    st_commit_ack = 1'b1;
    expect_cyc(1'b1, 2'd0, 4'b0000, 1'b1, 4'd15, 1'b0, 32'd7);
    st_commit_ack = 1'b0;
    clr();
    head_idx = 4'd0;
    slot(0, 1'b0, 1'b0, 1'b1, 5'd9);
    expect_cyc(1'b1, 2'd0, 4'b0001, 1'b0, 4'd15, 1'b0, 32'd8);

    // Lanes 0 and 2 both write r7, lane 1 killed: the youngest lane wins.
    clr();
    slot(0, 1'b0, 1'b0, 1'b1, 5'd7);
    slot(1, 1'b1, 1'b0, 1'b1, 5'd3);
    slot(2, 1'b0, 1'b0, 1'b1, 5'd7);
    expect_cyc(1'b1, 2'd2, 4'b0100, 1'b0, 4'd15, 1'b0, 32'd9);

    // Killed store passes, r0 is never written, and a live store at slot 3 stops the window.
    clr();
    slot(0, 1'b0, 1'b0, 1'b1, 5'd1);
    slot(1, 1'b1, 1'b1, 1'b0, 5'd0);
    slot(2, 1'b0, 1'b0, 1'b1, 5'd0);
    slot(3, 1'b0, 1'b1, 1'b0, 5'd0);
    expect_cyc(1'b1, 2'd2, 4'b0001, 1'b0, 4'd15, 1'b0, 32'd11);

    // Empty ROB.
    clr();
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd15, 1'b0, 32'd13);

    // Halt requested during a store handshake.
    head_idx = 4'd3;
    slot(0, 1'b0, 1'b1, 1'b0, 5'd0);
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd15, 1'b0, 32'd13);
    halt_req = 1'b1;
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b1, 4'd3, 1'b0, 32'd13);
    st_commit_ack = 1'b1;
    expect_cyc(1'b1, 2'd0, 4'b0000, 1'b1, 4'd3, 1'b0, 32'd13);
    st_commit_ack = 1'b0;
    clr();
    head_idx = 4'd4;
    slot(0, 1'b0, 1'b0, 1'b1, 5'd10);
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd3, 1'b1, 32'd14);
    halt_req = 1'b0;
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd3, 1'b1, 32'd14);
    expect_cyc(1'b1, 2'd0, 4'b0001, 1'b0, 4'd3, 1'b0, 32'd14);

    // Halt requested while in RUN.
    halt_req = 1'b1;
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd3, 1'b0, 32'd15);
    halt_req = 1'b0;
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd3, 1'b1, 32'd15);
    expect_cyc(1'b1, 2'd0, 4'b0001, 1'b0, 4'd3, 1'b0, 32'd15);

    // Reset while waiting for a store ack; a later ack is ignored.
    clr();
    head_idx = 4'd7;
    slot(0, 1'b0, 1'b1, 1'b0, 5'd0);
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd3, 1'b0, 32'd16);
    reset_n = 1'b0;
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b1, 4'd7, 1'b0, 32'd16);
    reset_n = 1'b1;
    clr();
    st_commit_ack = 1'b1;
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 32'd0);
    st_commit_ack = 1'b0;
    expect_cyc(1'b0, 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 32'd0);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
